mem_stage_access: RTL and testbench
===================================

Name: mem_stage_access

Overview:
- Consumer end of the EX/MEM pipeline register: takes the registered M-stage memory controls and address/store data and runs the data-memory bus handshake.
- Produces aligned, sign- or zero-extended load data, the LL/SC result and address-error flags.
- Drives M_Stall for the duration of each access.
- Sits between the EX/MEM register outputs and the MEM/WB register inputs.

Parameters:
ADDR_WIDTH, 30, width of the word address on the data-memory bus (byte address bits [ADDR_WIDTH+1:2])

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
M_MemRead  input  1  load in M stage
M_MemWrite  input  1  store in M stage
M_MemByte  input  1  byte-size access
M_MemHalf  input  1  half-size access (neither Byte nor Half means word)
M_MemSignExtend  input  1  sign-extend sub-word loads
M_ReverseEndian  input  1  little-endian lane mapping when 1, big-endian when 0
M_LLSC  input  1  LL when paired with MemRead, SC when paired with MemWrite
M_Flush  input  1  M-stage exception/flush; suppresses a not-yet-launched access
Eret  input  1  clears the LL bit
M_ALU_Result  input  32  byte address
M_ReadData2  input  32  store data
DataMem_In  input  32  read data from memory
DataMem_Ready  input  1  memory completes the request in this cycle
DataMem_Read  output  1  read request
DataMem_Write  output  4  byte-lane write enables (bit3 = bits[31:24])
DataMem_Address  output  ADDR_WIDTH  word address
DataMem_Out  output  32  lane-steered write data
M_Stall  output  1  hold the pipeline at M and earlier
M_MemReadData  output  32  extended load data, or SC result
M_MemDataValid  output  1  M_MemReadData valid this cycle
M_AddrErrLoad  output  1  misaligned load (combinational)
M_AddrErrStore  output  1  misaligned store (combinational)

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE and the LL bit is 0.
  - All registered outputs are 0: DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out, M_MemReadData, M_MemDataValid.
- An access is valid when (MemRead|MemWrite) & ~M_Flush & ~misaligned.
- Alignment rules:
  - Word accesses require addr[1:0]==0; half accesses require addr[0]==0.
  - A misaligned access raises M_AddrErrLoad or M_AddrErrStore in IDLE only.
  - A misaligned access issues no request and does not stall.
- SC with the LL bit clear is a failed SC:
  - No bus request; completes in the same cycle.
  - M_MemReadData=0 and M_MemDataValid=1 in that IDLE cycle; no stall.
- State IDLE:
  - M_Stall = valid access (combinational).
  - On a valid access, register the request outputs and go to REQ.
- State REQ:
  - M_Stall=1.
  - Request outputs are held stable until DataMem_Ready is sampled 1, then go to DONE.
  - On that edge, for reads, capture the steered/extended data into M_MemReadData.
  - M_Flush is ignored in REQ: a launched request always completes.
- State DONE:
  - M_Stall=0, M_MemDataValid=1, request outputs cleared.
  - For a successful SC, M_MemReadData=1.
  - Go to IDLE unconditionally.
- Minimum access latency is 3 cycles (IDLE, REQ, DONE) with Ready high on the first REQ cycle.
- Byte lanes:
  - Offset o = addr[1:0].
  - Big-endian byte lane = 3-o; little-endian lane = o.
  - Half: big-endian lanes {3-o, 2-o} selected by o[1]; little-endian lanes {o+1, o}.
- Store data: the byte or half is replicated across DataMem_Out; DataMem_Write enables only the addressed lanes; a word write uses 4'hF.
- Load data: the selected lane(s) are right-justified, then sign-extended (M_MemSignExtend=1) or zero-extended.
- LL bit:
  - Set on LL completion (entering DONE), with the word address recorded.
  - Cleared by successful SC completion, by Eret, and by any completed store to the recorded word address.
  - If Eret and LL completion coincide, Eret wins.
- Reset during REQ aborts immediately to IDLE; a late DataMem_Ready is ignored.

Decomposition:
- Shared package mem_access_pkg holds:
  - State encoding IDLE/REQ/DONE.
  - Size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - Lane-enable constants.
- One combinational sub-module, mem_lane_align, does store steering, byte-enable generation, and load extraction plus extension.
- The FSM, LL bit and handshake stay in mem_stage_access.

Test Plan:
- Word load, big-endian:
  - Stimulus: addr 0x100, DataMem_In=0x11223344, Ready high on the 3rd REQ cycle.
  - Response: Address=0x40, M_Stall high for 4 cycles, M_MemReadData=0x11223344 with Valid for 1 cycle.
- Byte load, signed:
  - Stimulus: addr 0x101, DataMem_In=0x11F23344; run big-endian, then ReverseEndian=1.
  - Response: big-endian gives 0xFFFFFFF2; little-endian gives 0x00000033.
- Half store, big-endian:
  - Stimulus: addr 0x202, ReadData2=0x0000ABCD.
  - Response: DataMem_Write=4'b0011, DataMem_Out=0xABCDABCD, held until Ready.
- Misaligned word store:
  - Stimulus: addr 0x203.
  - Response: M_AddrErrStore=1, no DataMem_Write, M_Stall=0.
- LL/SC sequence:
  - Stimulus: LL 0x300 completes, SC 0x300 issued; then a second SC.
  - Response: first SC writes and returns 1; second SC issues no bus cycle, returns 0, no stall.
  - Stimulus: LL, then Eret, then SC.
  - Response: SC returns 0.
- Reset mid-REQ:
  - Stimulus: reset low in REQ, Ready pulsed after release.
  - Response: all outputs 0, state IDLE, no Valid pulse.

Source files
------------

// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg: shared state, size and lane encodings for the M-stage access. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  localparam logic [3:0] LANE_NONE    = 4'b0000;
  localparam logic [3:0] LANE_B0      = 4'b0001;
  localparam logic [3:0] LANE_LO_HALF = 4'b0011;
  localparam logic [3:0] LANE_HI_HALF = 4'b1100;
  localparam logic [3:0] LANE_ALL     = 4'b1111;

  // Byte wins over half when both are asserted.
  function automatic size_t size_decode(input logic is_byte, input logic is_half);
    if (is_byte)      return SZ_BYTE;
    else if (is_half) return SZ_HALF;
    else              return SZ_WORD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align: store steering, byte enables, load extraction and extension. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_lane_align
  import mem_access_pkg::*;
(
  input  size_t       size_i,
  input  logic        sign_ext_i,
  input  logic        rev_endian_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_data_i,
  output logic [31:0] store_data_o,
  output logic [3:0]  byte_en_o,
  output logic [31:0] load_data_o
);

  logic [1:0]  lane_w;
  logic        hi_half_w;
  logic [31:0] byte_sh_w;
  logic [31:0] half_sh_w;

  // Big-endian lane 3-o is simply the bitwise inverse of o.
  assign lane_w    = rev_endian_i ? offset_i : ~offset_i;
  assign hi_half_w = rev_endian_i ? offset_i[1] : ~offset_i[1];
  assign byte_sh_w = load_data_i >> {lane_w, 3'b000};
  assign half_sh_w = load_data_i >> {hi_half_w, 4'b0000};

  always_comb begin
    store_data_o = store_data_i;
    byte_en_o    = LANE_ALL;
    load_data_o  = load_data_i;
    case (size_i)
      SZ_BYTE: begin
        store_data_o = {4{store_data_i[7:0]}};
        byte_en_o    = LANE_B0 << lane_w;
        load_data_o  = {{24{sign_ext_i & byte_sh_w[7]}}, byte_sh_w[7:0]};
      end
      SZ_HALF: begin
        store_data_o = {2{store_data_i[15:0]}};
        byte_en_o    = hi_half_w ? LANE_HI_HALF : LANE_LO_HALF;
        load_data_o  = {{16{sign_ext_i & half_sh_w[15]}}, half_sh_w[15:0]};
      end
      default: begin
        store_data_o = store_data_i;
        byte_en_o    = LANE_ALL;
        load_data_o  = load_data_i;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_access.sv
// ---------------------------------------------------------------------------
// mem_stage_access: M-stage data-memory handshake, LL/SC tracking, alignment checks. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_stage_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 30
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  M_MemRead,
  input  logic                  M_MemWrite,
  input  logic                  M_MemByte,
  input  logic                  M_MemHalf,
  input  logic                  M_MemSignExtend,
  input  logic                  M_ReverseEndian,
  input  logic                  M_LLSC,
  input  logic                  M_Flush,
  input  logic                  Eret,
  input  logic [31:0]           M_ALU_Result,
  input  logic [31:0]           M_ReadData2,
  input  logic [31:0]           DataMem_In,
  input  logic                  DataMem_Ready,
  output logic                  DataMem_Read,
  output logic [3:0]            DataMem_Write,
  output logic [ADDR_WIDTH-1:0] DataMem_Address,
  output logic [31:0]           DataMem_Out,
  output logic                  M_Stall,
  output logic [31:0]           M_MemReadData,
  output logic                  M_MemDataValid,
  output logic                  M_AddrErrLoad,
  output logic                  M_AddrErrStore
);

  state_t                state_q;
  logic                  ll_bit_q;
  logic [ADDR_WIDTH-1:0] ll_addr_q;
  logic                  read_q;
  logic                  write_q;
  logic                  llsc_q;
  size_t                 size_q;
  logic                  sign_q;
  logic                  rev_q;
  logic [1:0]            off_q;
  logic [3:0]            wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  dvalid_q;

  size_t       size_live_w;
  size_t       size_sel_w;
  logic        is_idle_w;
  logic        misaligned_w;
  logic        valid_w;
  logic        sc_fail_w;
  logic        launch_w;
  logic [31:0] wdata_w;
  logic [3:0]  be_w;
  logic [31:0] rdata_w;

  assign size_live_w  = size_decode(M_MemByte, M_MemHalf);
  assign is_idle_w    = (state_q == ST_IDLE);
  assign misaligned_w = ((size_live_w == SZ_WORD) && (M_ALU_Result[1:0] != 2'b00)) ||
                        ((size_live_w == SZ_HALF) && M_ALU_Result[0]);
  assign valid_w      = (M_MemRead | M_MemWrite) & ~M_Flush & ~misaligned_w;
  assign sc_fail_w    = is_idle_w & valid_w & M_MemWrite & M_LLSC & ~ll_bit_q;
  assign launch_w     = is_idle_w & valid_w & ~sc_fail_w;

  assign M_AddrErrLoad  = is_idle_w & M_MemRead & misaligned_w;
  assign M_AddrErrStore = is_idle_w & M_MemWrite & misaligned_w;
  assign M_Stall        = launch_w | (state_q == ST_REQ);
  // A failed SC resolves in IDLE without a bus cycle, so its result bypasses the register.
  assign M_MemDataValid = dvalid_q | sc_fail_w;
  assign M_MemReadData  = sc_fail_w ? 32'd0 : rdata_q;

  assign DataMem_Read    = read_q;
  assign DataMem_Write   = wen_q;
  assign DataMem_Address = addr_q;
  assign DataMem_Out     = wdata_q;

  // Live controls steer store data at launch; captured controls extract load data in REQ.
  assign size_sel_w = is_idle_w ? size_live_w : size_q;

  mem_lane_align u_align (
    .size_i       (size_sel_w),
    .sign_ext_i   (is_idle_w ? M_MemSignExtend : sign_q),
    .rev_endian_i (is_idle_w ? M_ReverseEndian : rev_q),
    .offset_i     (is_idle_w ? M_ALU_Result[1:0] : off_q),
    .store_data_i (M_ReadData2),
    .load_data_i  (DataMem_In),
    .store_data_o (wdata_w),
    .byte_en_o    (be_w),
    .load_data_o  (rdata_w)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ll_bit_q  <= 1'b0;
      ll_addr_q <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      llsc_q    <= 1'b0;
      size_q    <= SZ_WORD;
      sign_q    <= 1'b0;
      rev_q     <= 1'b0;
      off_q     <= 2'b00;
      wen_q     <= LANE_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      dvalid_q  <= 1'b0;
    end else begin
      dvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (launch_w) begin
            state_q <= ST_REQ;
            read_q  <= M_MemRead;
            write_q <= M_MemWrite;
            llsc_q  <= M_LLSC;
            size_q  <= size_live_w;
            sign_q  <= M_MemSignExtend;
            rev_q   <= M_ReverseEndian;
            off_q   <= M_ALU_Result[1:0];
            wen_q   <= M_MemWrite ? be_w : LANE_NONE;
            addr_q  <= M_ALU_Result[ADDR_WIDTH+1:2];
            wdata_q <= M_MemWrite ? wdata_w : 32'd0;
          end
        end
        ST_REQ: begin
          if (DataMem_Ready) begin
            state_q  <= ST_DONE;
            dvalid_q <= 1'b1;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            wen_q    <= LANE_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            if (read_q) begin
              rdata_q <= rdata_w;
            end else if (llsc_q) begin
              rdata_q <= 32'd1;
            end
            if (read_q && llsc_q) begin
              ll_bit_q  <= 1'b1;
              ll_addr_q <= addr_q;
            end
            if (write_q && (llsc_q || (addr_q == ll_addr_q))) begin
              ll_bit_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Placed last so it overrides a coincident LL completion.
      if (Eret) begin
        ll_bit_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_access.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_access: randomized and directed checks of mem_stage_access. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage_access;

  logic        clock = 1'b0;
  logic        reset;
  logic        M_MemRead, M_MemWrite, M_MemByte, M_MemHalf;
  logic        M_MemSignExtend, M_ReverseEndian, M_LLSC, M_Flush, Eret;
  logic [31:0] M_ALU_Result, M_ReadData2, DataMem_In;
  logic        DataMem_Ready;
  logic        DataMem_Read;
  logic [3:0]  DataMem_Write;
  logic [29:0] DataMem_Address;
  logic [31:0] DataMem_Out;
  logic        M_Stall;
  logic [31:0] M_MemReadData;
  logic        M_MemDataValid, M_AddrErrLoad, M_AddrErrStore;

  int n_cmp = 0;
  int n_err = 0;

  bit          model_ll = 1'b0;
  logic [31:0] model_ll_addr = '0;

  mem_stage_access #(.ADDR_WIDTH(30)) dut (
    .clock(clock), .reset(reset),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_MemByte(M_MemByte),
    .M_MemHalf(M_MemHalf), .M_MemSignExtend(M_MemSignExtend),
    .M_ReverseEndian(M_ReverseEndian), .M_LLSC(M_LLSC), .M_Flush(M_Flush),
    .Eret(Eret), .M_ALU_Result(M_ALU_Result), .M_ReadData2(M_ReadData2),
    .DataMem_In(DataMem_In), .DataMem_Ready(DataMem_Ready),
    .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write),
    .DataMem_Address(DataMem_Address), .DataMem_Out(DataMem_Out),
    .M_Stall(M_Stall), .M_MemReadData(M_MemReadData),
    .M_MemDataValid(M_MemDataValid), .M_AddrErrLoad(M_AddrErrLoad),
    .M_AddrErrStore(M_AddrErrStore)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // sz: 0 byte, 1 half, 2 word
  function automatic logic [3:0] exp_lanes(input int sz, input bit rev, input int o);
    int m;
    if (sz == 0)      m = rev ? (1 << o) : (1 << (3 - o));
    else if (sz == 1) m = rev ? ((1 << (o + 1)) | (1 << o)) : ((1 << (3 - o)) | (1 << (2 - o)));
    else              m = 15;
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_load(input int sz, input bit sx, input bit rev,
                                           input int o, input logic [31:0] mem);
    int lo;
    logic [31:0] v;
    if (sz == 2) return mem;
    lo = rev ? o : ((sz == 0) ? 3 - o : 2 - o);
    v  = mem >> (8 * lo);
    if (sz == 0) begin
      v = v & 32'hFF;
      if (sx && v[7]) v = v | 32'hFFFFFF00;
    end else begin
      v = v & 32'hFFFF;
      if (sx && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic clear_inputs();
    M_MemRead = 0; M_MemWrite = 0; M_MemByte = 0; M_MemHalf = 0;
    M_MemSignExtend = 0; M_ReverseEndian = 0; M_LLSC = 0; M_Flush = 0;
    M_ALU_Result = '0; M_ReadData2 = '0;
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic run_access(input bit rd, input bit wr, input int sz, input bit sx,
                            input bit rev, input bit llsc, input bit flush,
                            input logic [31:0] addr, input logic [31:0] wdat,
                            input logic [31:0] mem, input int rdy_dly, input bit eret_at_rdy);
    bit mis, vld, scf, go;
    int o;
    logic [3:0]  lanes;
    logic [31:0] exp_out, exp_rd;
    o       = int'(addr[1:0]);
    mis     = (sz == 2 && o != 0) || (sz == 1 && (o % 2) != 0);
    vld     = (rd || wr) && !flush && !mis;
    scf     = vld && wr && llsc && !model_ll;
    go      = vld && !scf;
    lanes   = exp_lanes(sz, rev, o);
    exp_out = (sz == 0) ? wdat[7:0] * 32'h01010101 :
              (sz == 1) ? wdat[15:0] * 32'h00010001 : wdat;
    exp_rd  = exp_load(sz, sx, rev, o, mem);

    M_MemRead = rd; M_MemWrite = wr; M_MemByte = (sz == 0); M_MemHalf = (sz == 1);
    M_MemSignExtend = sx; M_ReverseEndian = rev; M_LLSC = llsc; M_Flush = flush;
    M_ALU_Result = addr; M_ReadData2 = wdat; DataMem_Ready = 0;
    @(negedge clock);
    chk("err_load", M_AddrErrLoad, rd && mis);
    chk("err_store", M_AddrErrStore, wr && mis);
    chk("stall_idle", M_Stall, go);
    chk("valid_idle", M_MemDataValid, scf);
    if (scf) chk("sc_fail_data", M_MemReadData, 32'd0);
    @(posedge clock); #1;
    clear_inputs();
    if (!go) begin
      @(negedge clock);
      chk("no_read", DataMem_Read, 0);
      chk("no_write", DataMem_Write, 0);
      chk("no_stall", M_Stall, 0);
      @(posedge clock); #1;
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      DataMem_Ready = (i == rdy_dly);
      DataMem_In    = (i == rdy_dly) ? mem : $urandom;
      Eret          = eret_at_rdy && (i == rdy_dly);
      @(negedge clock);
      chk("req_read", DataMem_Read, rd);
      chk("req_write", DataMem_Write, wr ? lanes : 4'h0);
      chk("req_addr", DataMem_Address, addr >> 2);
      if (wr) chk("req_out", DataMem_Out, exp_out);
      chk("req_stall", M_Stall, 1);
      chk("req_valid", M_MemDataValid, 0);
      @(posedge clock); #1;
    end
    DataMem_Ready = 0;
    Eret = 0;
    @(negedge clock);
    chk("done_valid", M_MemDataValid, 1);
    chk("done_stall", M_Stall, 0);
    chk("done_read", DataMem_Read, 0);
    chk("done_write", DataMem_Write, 0);
    if (rd) chk("load_data", M_MemReadData, exp_rd);
    else if (llsc) chk("sc_ok_data", M_MemReadData, 32'd1);
    if (rd && llsc) begin
      model_ll = 1; model_ll_addr = addr >> 2;
    end
    if (wr && (llsc || (addr >> 2) == model_ll_addr)) model_ll = 0;
    if (eret_at_rdy) model_ll = 0;
    @(posedge clock); #1;
  endtask

  task automatic pulse_eret();
    Eret = 1;
    @(posedge clock); #1;
    Eret = 0;
    model_ll = 0;
  endtask

  task automatic reset_mid_req();
    run_access_launch_only();
    reset = 0;
    #1;
    chk("rst_read", DataMem_Read, 0);
    chk("rst_write", DataMem_Write, 0);
    chk("rst_addr", DataMem_Address, 0);
    chk("rst_out", DataMem_Out, 0);
    chk("rst_valid", M_MemDataValid, 0);
    chk("rst_stall", M_Stall, 0);
    chk("rst_data", M_MemReadData, 0);
    model_ll = 0;
    @(posedge clock); #1;
    reset = 1;
    DataMem_Ready = 1;
    DataMem_In = 32'hDEADBEEF;
    @(negedge clock);
    chk("late_rdy_valid", M_MemDataValid, 0);
    chk("late_rdy_stall", M_Stall, 0);
    @(posedge clock); #1;
    DataMem_Ready = 0;
    @(negedge clock);
    chk("late_rdy_valid2", M_MemDataValid, 0);
    chk("late_rdy_read", DataMem_Read, 0);
    @(posedge clock); #1;
  endtask

  task automatic run_access_launch_only();
    M_MemRead = 1; M_ALU_Result = 32'h500; DataMem_Ready = 0;
    @(posedge clock); #1;
    clear_inputs();
    @(negedge clock);
    chk("midreq_read", DataMem_Read, 1);
    chk("midreq_stall", M_Stall, 1);
  endtask

  initial begin
    bit rd, llsc, sx, rev, flush, er;
    int sz, dly;
    logic [31:0] a;
    reset = 0; Eret = 0; DataMem_Ready = 0; DataMem_In = '0;
    clear_inputs();
    #1;
    chk("reset_read", DataMem_Read, 0);
    chk("reset_write", DataMem_Write, 0);
    chk("reset_addr", DataMem_Address, 0);
    chk("reset_out", DataMem_Out, 0);
    chk("reset_data", M_MemReadData, 0);
    chk("reset_valid", M_MemDataValid, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1;
    @(posedge clock); #1;

    // Directed cases from the access plan
    run_access(1, 0, 2, 0, 0, 0, 0, 32'h100, 0, 32'h11223344, 2, 0);
    run_access(1, 0, 0, 1, 0, 0, 0, 32'h101, 0, 32'h11F23344, 0, 0);
    run_access(1, 0, 0, 1, 1, 0, 0, 32'h101, 0, 32'h11F23344, 1, 0);
    run_access(0, 1, 1, 0, 0, 0, 0, 32'h202, 32'h0000ABCD, 0, 2, 0);
    run_access(0, 1, 2, 0, 0, 0, 0, 32'h203, 32'h12345678, 0, 0, 0);
    run_access(1, 0, 2, 0, 0, 1, 0, 32'h300, 0, 32'hCAFEF00D, 0, 0);
    run_access(0, 1, 2, 0, 0, 1, 0, 32'h300, 32'h55AA55AA, 0, 1, 0);
    run_access(0, 1, 2, 0, 0, 1, 0, 32'h300, 32'h55AA55AA, 0, 1, 0);
    run_access(1, 0, 2, 0, 0, 1, 0, 32'h300, 0, 32'h1, 0, 0);
    pulse_eret();
    run_access(0, 1, 2, 0, 0, 1, 0, 32'h300, 32'h77, 0, 0, 0);
    reset_mid_req();

    for (int n = 0; n < 300; n++) begin
      rd    = ($urandom % 2) == 0;
      sz    = $urandom % 3;
      sx    = $urandom % 2;
      rev   = $urandom % 2;
      llsc  = ($urandom % 3) == 0;
      flush = ($urandom % 10) == 0;
      er    = ($urandom % 8) == 0;
      dly   = $urandom % 4;
      a     = 32'h400 + 32'(($urandom % 4) * 4) + 32'($urandom % 4);
      if ($urandom % 10 == 0) pulse_eret();
      run_access(rd, !rd, sz, sx, rev, llsc, flush, a, $urandom, $urandom, dly, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
